dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core.
//   Accepts one load/store request at a time over a valid/ready handshake.
//   Performs the word access after a fixed latency and returns read data with a
//   one-cycle resp_valid pulse.
//   Drives stall to the hazard unit while an access is outstanding.
// PARAMETERS
//   DEPTH_WORDS  256  memory size in 32-bit words; power of two, >= 4
//   LATENCY      2    cycles from request acceptance to resp_valid; >= 1
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request this cycle
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address (ALU result)
//   req_wdata   in   32  store data
//   req_be      in   4   store byte enables; be[i] covers bits 8i+7:8i
//   resp_valid  out  1   one-cycle pulse: access complete
//   resp_rdata  out  32  load data, valid with resp_valid
//   stall       out  1   hold upstream pipeline registers
// BEHAVIOUR
//   Reset (rst high at clk edge): state=IDLE, count=0, resp_valid=0, resp_rdata=0.
//     Memory array is not cleared.
//     A pending store is abandoned: the memory is not written.
//   States: IDLE, BUSY, RESP.
//   req_ready = (state==IDLE) | (state==RESP). It is combinational from state only.
//   Accept: req_valid & req_ready at edge of cycle T.
//     Captures we, addr, wdata and be. Later changes on the req_* inputs are ignored.
//   Accept transitions:
//     - LATENCY==1: go to RESP.
//     - LATENCY>1: go to BUSY with count=LATENCY-1.
//   BUSY: count decrements each cycle. At count==1 the next state is RESP.
//   RESP (cycle T+LATENCY): resp_valid=1.
//     - Load: resp_rdata = mem[word].
//     - Store: resp_rdata = 0.
//     - If req_valid is high, the next request is accepted the same cycle (back-to-back).
//       Otherwise go to IDLE.
//   Store commit: mem[word] bytes with be[i]=1 are updated at the edge ending cycle T+LATENCY.
//     A load accepted in RESP therefore sees the new data.
//     be=4'b0000 is a no-op store that still produces resp_valid.
//   Load data is read at cycle T+LATENCY from the array, after all earlier commits.
//   Word index = req_addr[log2(DEPTH_WORDS)+1:2].
//     addr[1:0] is ignored (no alignment trap).
//     Upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
//   resp_rdata holds its last value outside resp_valid.
//   stall = (state==BUSY) | (req_valid & req_ready & ~(state==RESP & ~req_valid)).
//     Net effect: stall is high from the acceptance cycle T through T+LATENCY-1.
//     stall is low in the RESP cycle unless a new request is accepted in it.
//   req_valid in BUSY is not an error: it waits, with ready=0.
// TESTING
//   1. LATENCY=2: store 0xDEADBEEF @0x10 be=F, then load @0x10
//      -> resp_valid at T+2 both times; load rdata=0xDEADBEEF.
//   2. Word 0x20 holds 0x11223344; store 0xAABBCCDD @0x20 be=0101, load
//      -> 0x11BB33DD.
//   3. Back-to-back: store 0x5 @0x0, load @0x0 accepted in the RESP cycle
//      -> rdata=0x5; ready=1 in RESP.
//   4. rst asserted in BUSY of a store @0x40 (old value 0x7)
//      -> next cycle resp_valid=0, ready=1; load @0x40 returns 0x7.
//   5. DEPTH_WORDS=256: store 0xCAFE @0x400, load @0x000 -> 0xCAFE;
//      load @0x403 returns word @0x400.
//   6. LATENCY=3, single load -> stall=1 for cycles T..T+2, 0 at T+3;
//      resp_valid a single pulse.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: one request in flight,
// fixed latency, one-cycle resp_valid pulse, stall held while an access is pending.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            cap_we;
  logic [AW-1:0]   cap_word;
  logic [31:0]     cap_wdata;
  logic [3:0]      cap_be;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            to_resp;
  logic            commit;
  logic            rsp_we;
  logic [AW-1:0]   rsp_word;
  logic [AW-1:0]   req_word;
  logic [31:0]     rd_word;
  logic [31:0]     next_rdata;
  logic            addr_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  assign req_word    = req_addr[AW+1:2];
  assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign req_ready = (state == IDLE) || (state == RESP);
  assign accept    = req_valid && req_ready;
  assign stall     = (state == BUSY) || (accept && !((state == RESP) && !req_valid));
  // A store in RESP writes at the closing edge; a reset on that edge abandons it.
  assign commit    = (state == RESP) && cap_we && !rst;

  always_comb begin
    to_resp    = 1'b0;
    rsp_we     = cap_we;
    rsp_word   = cap_word;
    rd_word    = 32'h0000_0000;
    next_rdata = 32'h0000_0000;
    if (accept && (LATENCY == 1)) begin
      to_resp  = 1'b1;
      rsp_we   = req_we;
      rsp_word = req_word;
    end else if ((state == BUSY) && (count == CW'(1))) begin
      to_resp = 1'b1;
    end else begin
      to_resp = 1'b0;
    end
    // Forward a store committing on the same edge so the load sees post-commit data.
    rd_word = mem[rsp_word];
    if (commit && (cap_word == rsp_word)) begin
      rd_word = merge_bytes(rd_word, cap_wdata, cap_be);
    end else begin
      rd_word = mem[rsp_word];
    end
    next_rdata = rsp_we ? 32'h0000_0000 : rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      cap_we     <= 1'b0;
      cap_word   <= '0;
      cap_wdata  <= 32'h0000_0000;
      cap_be     <= 4'b0000;
    end else begin
      resp_valid <= to_resp;
      if (to_resp) begin
        resp_rdata <= next_rdata;
      end
      if (accept) begin
        cap_we    <= req_we;
        cap_word  <= req_word;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              count <= CW'(LATENCY - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (count == CW'(1)) begin
            state <= RESP;
          end
          count <= count - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cap_word] <= merge_bytes(mem[cap_word], cap_wdata, cap_be);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for data/handshake cases,
// LATENCY=3 instance for the stall/pulse timing case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, stall;
  logic [31:0] resp_rdata;

  logic        b_valid, b_we;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_ready, b_resp_valid, b_stall;
  logic [31:0] b_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rdata;
  int          lat;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .stall(b_stall)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance and wait (bounded) for its response.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rd, output int cycles);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD; req_be = 4'hF;
    cycles = 1;
    while (!resp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    rd = resp_rdata;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_value("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check_value("reset resp_rdata", resp_rdata, 32'h0000_0000);
    check_value("reset ready", {31'd0, req_ready}, 32'd1);
    check_value("reset stall", {31'd0, stall}, 32'd0);

    // 1: store then load, latency 2
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rdata, lat);
    check_value("t1 store latency", lat, 32'd2);
    check_value("t1 store rdata", rdata, 32'h0000_0000);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rdata, lat);
    check_value("t1 load latency", lat, 32'd2);
    check_value("t1 load rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check_value("t1 rdata hold", resp_rdata, 32'hDEAD_BEEF);
    check_value("t1 pulse end", {31'd0, resp_valid}, 32'd0);

    // 2: partial byte store
    xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, rdata, lat);
    xfer(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rdata, lat);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, rdata, lat);
    check_value("t2 byte merge", rdata, 32'h11BB_33DD);

    // 3: back-to-back load accepted in the store's RESP cycle
    xfer(1'b1, 32'h0, 32'h0000_0005, 4'hF, rdata, lat);
    check_value("t3 ready in resp", {31'd0, req_ready}, 32'd1);
    check_value("t3 stall resp idle", {31'd0, stall}, 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
    #1;
    check_value("t3 stall on b2b accept", {31'd0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_value("t3 no resp at T+1", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check_value("t3 resp at T+2", {31'd0, resp_valid}, 32'd1);
    check_value("t3 b2b rdata", resp_rdata, 32'h0000_0005);

    // 4: reset while a store is in BUSY abandons it
    xfer(1'b1, 32'h40, 32'h0000_0007, 4'hF, rdata, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0000_0099; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_value("t4 busy stall", {31'd0, stall}, 32'd1);
    check_value("t4 busy ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_value("t4 post-rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check_value("t4 post-rst ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check_value("t4 no late resp", {31'd0, resp_valid}, 32'd0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rdata, lat);
    check_value("t4 store abandoned", rdata, 32'h0000_0007);

    // 5: address wrap and ignored low bits
    xfer(1'b1, 32'h400, 32'h0000_CAFE, 4'hF, rdata, lat);
    xfer(1'b0, 32'h000, 32'h0, 4'h0, rdata, lat);
    check_value("t5 wrap load", rdata, 32'h0000_CAFE);
    xfer(1'b0, 32'h403, 32'h0, 4'h0, rdata, lat);
    check_value("t5 unaligned load", rdata, 32'h0000_CAFE);
    xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rdata, lat);
    check_value("t5 be0 latency", lat, 32'd2);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rdata, lat);
    check_value("t5 be0 no-op", rdata, 32'hDEAD_BEEF);

    // 6: LATENCY=3 stall window and single pulse
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h8;
    #1;
    check_value("t6 stall T", {31'd0, b_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    check_value("t6 stall T+1", {31'd0, b_stall}, 32'd1);
    check_value("t6 resp T+1", {31'd0, b_resp_valid}, 32'd0);
    @(negedge clk);
    check_value("t6 stall T+2", {31'd0, b_stall}, 32'd1);
    check_value("t6 resp T+2", {31'd0, b_resp_valid}, 32'd0);
    @(negedge clk);
    check_value("t6 stall T+3", {31'd0, b_stall}, 32'd0);
    check_value("t6 resp T+3", {31'd0, b_resp_valid}, 32'd1);
    @(negedge clk);
    check_value("t6 resp T+4", {31'd0, b_resp_valid}, 32'd0);
    check_value("t6 ready T+4", {31'd0, b_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
